// File: rtl/mem_types_pkg.sv
// Shared memory-subsystem types and sizing constants.
// Holds the snoop request queue depth, its slow-down threshold and the
// packed snoop request record used by the dcache snoop path.
package mem_types_pkg;

  localparam int BLOCK_ADDR_SPACE_WIDTH                 = 26;
  localparam int DCACHE_SNOOP_REQ_Q_DEPTH               = 4;
  localparam int DCACHE_SNOOP_REQ_Q_LOG_DEPTH           = $clog2(DCACHE_SNOOP_REQ_Q_DEPTH);
  localparam int DCACHE_SNOOP_REQ_Q_SLOW_DOWN_THRESHOLD = (3 * DCACHE_SNOOP_REQ_Q_DEPTH) / 4;

  typedef struct packed {
    logic [BLOCK_ADDR_SPACE_WIDTH-1:0] block_addr;
    logic                              exclusive;
  } snoop_req_t;

endpackage

// File: rtl/dcache_snoop_req_q.sv
// Dcache snoop request queue: circular FIFO of snooped block addresses with
// an associative search port and a registered occupancy / slow-down flag.
// Optional build macro DCACHE_SNOOP_REQ_Q_COALESCE_EN: an enqueue that
// matches a live entry merges its exclusive bit instead of allocating.
module dcache_snoop_req_q
  import mem_types_pkg::*;
#(
  parameter int DEPTH               = DCACHE_SNOOP_REQ_Q_DEPTH,
  parameter int ADDR_W              = BLOCK_ADDR_SPACE_WIDTH,
  parameter int SLOW_DOWN_THRESHOLD = DCACHE_SNOOP_REQ_Q_SLOW_DOWN_THRESHOLD
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     enq_valid,
  input  logic [ADDR_W-1:0]        enq_block_addr,
  input  logic                     enq_exclusive,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output logic [ADDR_W-1:0]        deq_block_addr,
  output logic                     deq_exclusive,
  input  logic                     deq_ready,
  input  logic [ADDR_W-1:0]        search_block_addr,
  output logic                     search_hit,
  output logic                     search_exclusive,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     slow_down
);

  localparam int LD    = $clog2(DEPTH);
  localparam int CNT_W = LD + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] block_addr;
    logic              exclusive;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [LD-1:0]      r_head;
  logic [LD-1:0]      r_tail;
  logic [DEPTH-1:0]   r_valid;
  logic [CNT_W-1:0]   r_count;
  logic               r_slow_down;

  logic               w_full;
  logic               w_enq_fire;
  logic               w_deq_fire;
  logic               w_alloc;
  logic [DEPTH-1:0]   w_coal_match;
  logic [DEPTH-1:0]   w_valid_next;
  logic [CNT_W-1:0]   w_count_next;

  assign w_full         = (r_count == CNT_W'(DEPTH));
  assign deq_valid      = (r_count != {CNT_W{1'b0}});
  assign deq_block_addr = r_mem[r_head].block_addr;
  assign deq_exclusive  = r_mem[r_head].exclusive;
  assign count          = r_count;
  assign slow_down      = r_slow_down;
  assign w_deq_fire     = deq_valid & deq_ready;

`ifdef DCACHE_SNOOP_REQ_Q_COALESCE_EN
  // Find live entries the incoming address can merge into; a head leaving this cycle is not a target.
  always_comb begin
    w_coal_match = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_mem[i].block_addr == enq_block_addr) &&
          !(w_deq_fire && (r_head == LD'(i)))) begin
        w_coal_match[i] = 1'b1;
      end else begin
        w_coal_match[i] = 1'b0;
      end
    end
  end
`else
  assign w_coal_match = {DEPTH{1'b0}};
`endif

  // A merging enqueue needs no free slot; a dequeue never frees space for this cycle's enqueue.
  assign enq_ready  = ~w_full | (|w_coal_match);
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_alloc    = w_enq_fire & ~(|w_coal_match);

  // Next valid mask and occupancy from this cycle's allocate / dequeue.
  always_comb begin
    w_valid_next = r_valid;
    if (w_deq_fire) begin
      w_valid_next[r_head] = 1'b0;
    end else begin
      w_valid_next[r_head] = r_valid[r_head];
    end
    if (w_alloc) begin
      w_valid_next[r_tail] = 1'b1;
    end else begin
      w_valid_next[r_tail] = w_valid_next[r_tail];
    end
    case ({w_alloc, w_deq_fire})
      2'b10:   w_count_next = r_count + CNT_W'(1'b1);
      2'b01:   w_count_next = r_count - CNT_W'(1'b1);
      default: w_count_next = r_count;
    endcase
  end

  // Associative probe over entries valid at the start of the cycle.
  always_comb begin
    search_hit       = 1'b0;
    search_exclusive = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_mem[i].block_addr == search_block_addr)) begin
        search_hit       = 1'b1;
        search_exclusive = search_exclusive | r_mem[i].exclusive;
      end else begin
        search_hit       = search_hit;
        search_exclusive = search_exclusive;
      end
    end
  end

  // Pointer, valid-bit and occupancy state; reset discards every entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head      <= {LD{1'b0}};
      r_tail      <= {LD{1'b0}};
      r_valid     <= {DEPTH{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_slow_down <= 1'b0;
    end else begin
      if (w_deq_fire) begin
        r_head <= r_head + LD'(1'b1);
      end
      if (w_alloc) begin
        r_tail <= r_tail + LD'(1'b1);
      end
      r_valid     <= w_valid_next;
      r_count     <= w_count_next;
      r_slow_down <= (w_count_next >= CNT_W'(SLOW_DOWN_THRESHOLD));
    end
  end

  // Entry payload storage: written on allocate, exclusive bit merged on coalesce.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc && (r_tail == LD'(i))) begin
        r_mem[i].block_addr <= enq_block_addr;
        r_mem[i].exclusive  <= enq_exclusive;
      end else if (w_enq_fire && w_coal_match[i]) begin
        r_mem[i].exclusive  <= r_mem[i].exclusive | enq_exclusive;
      end
    end
  end

endmodule

// File: tb/tb_dcache_snoop_req_q.sv
// Directed testbench for dcache_snoop_req_q (DEPTH=4, threshold 3).
module tb_dcache_snoop_req_q;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       enq_valid;
  logic [7:0] enq_block_addr;
  logic       enq_exclusive;
  logic       enq_ready;
  logic       deq_valid;
  logic [7:0] deq_block_addr;
  logic       deq_exclusive;
  logic       deq_ready;
  logic [7:0] search_block_addr;
  logic       search_hit;
  logic       search_exclusive;
  logic [2:0] count;
  logic       slow_down;

  int checks   = 0;
  int failures = 0;

  dcache_snoop_req_q #(
    .DEPTH               (4),
    .ADDR_W              (8),
    .SLOW_DOWN_THRESHOLD (3)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .enq_valid         (enq_valid),
    .enq_block_addr    (enq_block_addr),
    .enq_exclusive     (enq_exclusive),
    .enq_ready         (enq_ready),
    .deq_valid         (deq_valid),
    .deq_block_addr    (deq_block_addr),
    .deq_exclusive     (deq_exclusive),
    .deq_ready         (deq_ready),
    .search_block_addr (search_block_addr),
    .search_hit        (search_hit),
    .search_exclusive  (search_exclusive),
    .count             (count),
    .slow_down         (slow_down)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the falling edge so registered outputs are settled.
  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
  endtask

  initial begin
    int ncoal;
    nRST = 1'b0;
    enq_valid = 1'b0;
    enq_block_addr = 8'h00;
    enq_exclusive = 1'b0;
    deq_ready = 1'b0;
    search_block_addr = 8'h00;

    // Reset state
    @(negedge CLK);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
    chk("rst_search_hit", {31'd0, search_hit}, 32'd0);
    chk("rst_slow_down", {31'd0, slow_down}, 32'd0);
    nRST = 1'b1;
    tick();

    // Fill to full back-to-back
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1;
      enq_block_addr = 8'h10 + 8'(k);
      enq_exclusive = 1'b0;
      tick();
      chk("fill_count", {29'd0, count}, 32'(k + 1));
      chk("fill_slow_down", {31'd0, slow_down}, (k >= 2) ? 32'd1 : 32'd0);
      chk("fill_enq_ready", {31'd0, enq_ready}, (k < 3) ? 32'd1 : 32'd0);
    end
    idle();
    #1;
    chk("fill_head", {24'd0, deq_block_addr}, 32'h10);

    // Full: enqueue and dequeue together -> only the dequeue fires
    enq_valid = 1'b1;
    enq_block_addr = 8'h14;
    deq_ready = 1'b1;
    #1;
    chk("full_enq_ready", {31'd0, enq_ready}, 32'd0);
    tick();
    idle();
    chk("full_count", {29'd0, count}, 32'd3);
    chk("full_enq_ready_after", {31'd0, enq_ready}, 32'd1);
    chk("full_head_after", {24'd0, deq_block_addr}, 32'h11);

    // Drain remaining entries in order
    for (int k = 1; k < 4; k++) begin
      deq_ready = 1'b1;
      #1;
      chk("drain_order", {24'd0, deq_block_addr}, 32'h10 + 32'(k));
      tick();
    end
    idle();
    chk("drain_empty", {31'd0, deq_valid}, 32'd0);

    // Move head to 2 and tail to 3, leaving one entry (0x42)
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1'b1;
      enq_block_addr = 8'h40 + 8'(k);
      tick();
    end
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    tick();
    tick();
    idle();
    chk("wrap_pre_count", {29'd0, count}, 32'd1);

    // Six cycles of enqueue + dequeue across the pointer wrap
    for (int k = 0; k < 6; k++) begin
      enq_valid = 1'b1;
      enq_block_addr = 8'h50 + 8'(k);
      deq_ready = 1'b1;
      #1;
      chk("wrap_order", {24'd0, deq_block_addr}, (k == 0) ? 32'h42 : 32'h50 + 32'(k - 1));
      tick();
      chk("wrap_count", {29'd0, count}, 32'd1);
    end
    enq_valid = 1'b0;
    #1;
    chk("wrap_last", {24'd0, deq_block_addr}, 32'h55);
    tick();
    idle();
    chk("wrap_empty", {29'd0, count}, 32'd0);

    // Search port
    enq_valid = 1'b1;
    enq_block_addr = 8'h20;
    enq_exclusive = 1'b0;
    search_block_addr = 8'h20;
    #1;
    chk("search_enq_cycle", {31'd0, search_hit}, 32'd0);
    tick();
    enq_block_addr = 8'h21;
    enq_exclusive = 1'b1;
    tick();
    idle();
    enq_exclusive = 1'b0;
    search_block_addr = 8'h21;
    #1;
    chk("search21_hit", {31'd0, search_hit}, 32'd1);
    chk("search21_excl", {31'd0, search_exclusive}, 32'd1);
    search_block_addr = 8'h20;
    #1;
    chk("search20_hit", {31'd0, search_hit}, 32'd1);
    chk("search20_excl", {31'd0, search_exclusive}, 32'd0);
    search_block_addr = 8'h22;
    #1;
    chk("search22_hit", {31'd0, search_hit}, 32'd0);
    search_block_addr = 8'h20;
    deq_ready = 1'b1;
    #1;
    chk("search_deq_cycle", {31'd0, search_hit}, 32'd1);
    tick();
    chk("search_after_deq", {31'd0, search_hit}, 32'd0);
    tick();
    idle();
    chk("search_empty", {29'd0, count}, 32'd0);

    // Duplicate addresses: coalesced or allocated depending on build
    enq_valid = 1'b1;
    enq_block_addr = 8'h30;
    enq_exclusive = 1'b0;
    tick();
    enq_exclusive = 1'b1;
    tick();
    idle();
    enq_exclusive = 1'b0;
`ifdef DCACHE_SNOOP_REQ_Q_COALESCE_EN
    ncoal = 1;
    chk("dup_head_excl", {31'd0, deq_exclusive}, 32'd1);
`else
    ncoal = 2;
    chk("dup_head_excl", {31'd0, deq_exclusive}, 32'd0);
`endif
    chk("dup_count", {29'd0, count}, 32'(ncoal));
    deq_ready = 1'b1;
    for (int k = 0; k < ncoal; k++) tick();
    idle();
    chk("dup_empty", {29'd0, count}, 32'd0);

    // Asynchronous reset mid-stream with three entries
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1'b1;
      enq_block_addr = 8'h60 + 8'(k);
      tick();
    end
    idle();
    chk("midrst_pre_count", {29'd0, count}, 32'd3);
    search_block_addr = 8'h60;
    nRST = 1'b0;
    #1;
    chk("midrst_count", {29'd0, count}, 32'd0);
    chk("midrst_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("midrst_enq_ready", {31'd0, enq_ready}, 32'd1);
    chk("midrst_search_hit", {31'd0, search_hit}, 32'd0);
    chk("midrst_slow_down", {31'd0, slow_down}, 32'd0);
    nRST = 1'b1;
    tick();
    enq_valid = 1'b1;
    enq_block_addr = 8'h70;
    tick();
    idle();
    chk("post_rst_count", {29'd0, count}, 32'd1);
    chk("post_rst_head", {24'd0, deq_block_addr}, 32'h70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_snoop_req_q.md
DCACHE_SNOOP_REQ_Q -- requirements
Module: dcache_snoop_req_q

Interface
REQ-001 SHALL have parameter DEPTH, default DCACHE_SNOOP_REQ_Q_DEPTH (4): entry count, power of two, >=2.
REQ-002 SHALL have parameter ADDR_W, default BLOCK_ADDR_SPACE_WIDTH: block address width.
REQ-003 SHALL have parameter SLOW_DOWN_THRESHOLD, default DCACHE_SNOOP_REQ_Q_SLOW_DOWN_THRESHOLD (3*DEPTH/4): occupancy that asserts slow_down.
REQ-004 CLK  in  1  clock, all state on rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 enq_valid  in  1  incoming snoop request.
REQ-007 enq_block_addr  in  ADDR_W  snooped block address.
REQ-008 enq_exclusive  in  1  snoop requires invalidation (BusRdX/upgrade).
REQ-009 enq_ready  out  1  request accepted this cycle when high with enq_valid.
REQ-010 deq_valid  out  1  head entry valid.
REQ-011 deq_block_addr  out  ADDR_W  head address.
REQ-012 deq_exclusive  out  1  head exclusive bit.
REQ-013 deq_ready  in  1  dcache consumes head.
REQ-014 search_block_addr  in  ADDR_W  address probed by dcache miss/store logic.
REQ-015 search_hit  out  1  any valid entry matches search_block_addr.
REQ-016 search_exclusive  out  1  OR of exclusive bits over matching entries.
REQ-017 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-018 slow_down  out  1  count >= SLOW_DOWN_THRESHOLD.

Function
REQ-019 SHALL be a circular FIFO: head/tail pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, per-entry valid bit.
REQ-020 Enqueue SHALL fire on enq_valid && enq_ready; entry written at tail, visible on deq_* next cycle (1-cycle latency, no same-cycle bypass).
REQ-021 Dequeue SHALL fire on deq_valid && deq_ready; head entry invalidated, head advances at the clock edge.
REQ-022 enq_ready SHALL equal (count != DEPTH); a dequeue in the same cycle while full does NOT raise enq_ready (no full-queue passthrough).
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged; both pointers advance.
REQ-024 deq_valid SHALL equal (count != 0); deq_* SHALL be driven from the head register only.
REQ-025 search_hit/search_exclusive SHALL be combinational over entries valid at cycle start; the entry being enqueued this cycle is not searched; the entry being dequeued this cycle is still searched.
REQ-026 count and slow_down SHALL be registered, updated with the same edge as the pointers.
REQ-027 enq_valid while enq_ready=0 SHALL change no state; the requester holds the request.

Reset
REQ-028 On nRST low, asynchronously: head=tail=0, all valid bits 0, count=0, slow_down=0; hence deq_valid=0, enq_ready=1, search_hit=0.
REQ-029 Reset mid-operation SHALL discard all entries; no dequeue is reported for discarded entries.
REQ-030 Entry address/exclusive storage need not be reset.

Configuration
REQ-031 With DCACHE_SNOOP_REQ_Q_COALESCE_EN defined: an enqueue whose address matches a valid entry SHALL NOT allocate; it ORs enq_exclusive into that entry, count unchanged, and enq_ready=1 even when full.
REQ-032 Coalescing SHALL exclude the head entry when it is dequeued the same cycle; that enqueue then allocates normally (subject to REQ-022).
REQ-033 Without the macro, every accepted enqueue allocates; duplicates are permitted.

Structure
REQ-034 mem_types_pkg SHALL gain typedef snoop_req_t (packed: block_addr [ADDR_W], exclusive) and DCACHE_SNOOP_REQ_Q_SLOW_DOWN_THRESHOLD; DCACHE_SNOOP_REQ_Q_DEPTH/LOG_DEPTH stay there.
REQ-035 Single module, no sub-module; address-match comparators are inline.

Verification (DEPTH=4, THRESHOLD=3)
REQ-036 Enq 0x10,0x11,0x12,0x13 back-to-back -> count 1..4, slow_down high after 3rd, enq_ready=0 after 4th; deq in order 0x10..0x13.
REQ-037 Full queue, enq_valid and deq_ready same cycle -> only dequeue fires, count 4->3, enq_ready=1 next cycle.
REQ-038 Tail at index 3, enq+deq every cycle for 6 cycles -> pointers wrap, FIFO order intact, count constant.
REQ-039 Entries {0x20 excl=0, 0x21 excl=1}; search 0x21 -> hit=1, excl=1; search 0x22 -> hit=0; search 0x20 in enqueue cycle of 0x20 -> hit=0.
REQ-040 COALESCE_EN: enq 0x30 excl=0 then 0x30 excl=1 -> count 1, single deq with excl=1; without macro -> count 2.
REQ-041 nRST pulsed low mid-stream with count=3 -> immediately count=0, deq_valid=0, enq_ready=1, search_hit=0.
